uart_cmd_decoder: RTL and testbench

UART receive path plus command decoder for the stopwatch/watch top. It receives 8N1 bytes from the PC terminal and decodes ASCII commands into single-cycle control pulses. These pulses are OR'd with the debounced Btn_R/Btn_L inputs ahead of stopwatch_cu, and a mode level replaces or augments sw_0. It is the input counterpart to the FND display path: the display shows time to the user, and this block takes commands from the user.

---
 rtl/uart_cmd_decoder.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// UART 8N1 receiver with ASCII command decoder.
// Received bytes become single-cycle run/stop and clear pulses plus a toggled
// display-mode level. The reset input is asynchronous and active-low.
module uart_cmd_decoder #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_runstop,
    output logic       o_clear,
    output logic       o_mode
);

    localparam int DIV = CLK_FREQ / (BAUD * OVS);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta_q, rx_sync_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick;

    state_t        state_q, state_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
    logic          runstop_q, runstop_d;
    logic          clear_q, clear_d;
    logic          mode_q, mode_d;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Free-running oversample tick divider.
    always_comb begin
        tick      = (div_cnt_q == DW'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    end

    // Receive FSM next state plus registered command decode of the previous byte.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        runstop_d   = 1'b0;
        clear_d     = 1'b0;
        mode_d      = mode_q;

        case (state_q)
            // Start edge is accepted on any clock so back-to-back frames are not lost.
            S_IDLE: begin
                if (!rx_sync_q) begin
                    tick_cnt_d = 4'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        if (rx_sync_q) begin
                            state_d = S_IDLE;
                        end else begin
                            tick_cnt_d = 4'd0;
                            bit_cnt_d  = 3'd0;
                            state_d    = S_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = 4'd0;
                        shift_d    = {rx_sync_q, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = 4'd0;
                        if (rx_sync_q) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            // A held-low line reports one framing error, then waits for idle.
            S_BREAK: begin
                if (rx_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_done_q) begin
            case (rx_data_q)
                8'h52, 8'h72: runstop_d = 1'b1;
                8'h43, 8'h63: clear_d   = 1'b1;
                8'h4D, 8'h6D: mode_d    = ~mode_q;
                default: ;
            endcase
        end
    end

    // Single state register for the FSM, counters, data path and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q   <= '0;
            state_q     <= S_IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            runstop_q   <= 1'b0;
            clear_q     <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            runstop_q   <= runstop_d;
            clear_q     <= clear_d;
            mode_q      <= mode_d;
        end
    end

    assign o_rx_data   = rx_data_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;
    assign o_runstop   = runstop_q;
    assign o_clear     = clear_q;
    assign o_mode      = mode_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected events,
// a monitor pops and compares whenever the DUT presents an output event.
module tb_uart_cmd_decoder;

    // DIV = 1_600_000 / (25_000 * 16) = 4 clocks per tick, 64 clocks per bit.
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 25_000;
    localparam int OVS      = 16;
    localparam int BIT      = 64;

    localparam int EV_DONE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_RUN  = 2;
    localparam int EV_CLR  = 3;
    localparam int EV_MODE = 4;
    localparam int EV_NONE = 5;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] o_rx_data;
    logic       o_rx_done, o_frame_err, o_runstop, o_clear, o_mode;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    uart_cmd_decoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .o_rx_data  (o_rx_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err),
        .o_runstop  (o_runstop),
        .o_clear    (o_clear),
        .o_mode     (o_mode)
    );

    always #5 clk = ~clk;

    function automatic void push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Good frame followed by its command event (EV_NONE for plain data).
    function automatic void expect_byte(input logic [7:0] b, input int cmd, input logic mode_val);
        push(EV_DONE, b);
        if (cmd == EV_MODE) push(EV_MODE, {7'd0, mode_val});
        else if (cmd != EV_NONE) push(cmd, 8'd0);
    endfunction

    task automatic check_ev(input int kind, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d data=%02h, expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                errors++;
                $display("FAIL event: got kind=%0d data=%02h, expected kind=%0d data=%02h",
                         kind, data, e.kind, e.data);
            end else begin
                $display("event kind=%0d data=%02h ok", kind, data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end else begin
            $display("check %s = %02h ok", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        rx = stop;
        repeat (BIT) @(posedge clk);
    endtask

    // Bounded wait for all expected events, then a quiet window for strays.
    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rx_data"}, o_rx_data, 8'h00);
        chk({name, "_rx_done"}, {7'd0, o_rx_done}, 8'h00);
        chk({name, "_frame_err"}, {7'd0, o_frame_err}, 8'h00);
        chk({name, "_runstop"}, {7'd0, o_runstop}, 8'h00);
        chk({name, "_clear"}, {7'd0, o_clear}, 8'h00);
        chk({name, "_mode"}, {7'd0, o_mode}, 8'h00);
    endtask

    // Monitor: every output event is checked against the scoreboard.
    initial begin
        logic prev_mode;
        logic prev_done;
        logic mode_chg;
        prev_mode = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_mode = 1'b0;
                prev_done = 1'b0;
            end else begin
                mode_chg = (o_mode != prev_mode);
                if (o_rx_done)   check_ev(EV_DONE, o_rx_data);
                if (o_frame_err) check_ev(EV_FERR, 8'd0);
                if (o_runstop)   check_ev(EV_RUN, 8'd0);
                if (o_clear)     check_ev(EV_CLR, 8'd0);
                if (mode_chg)    check_ev(EV_MODE, {7'd0, o_mode});
                if (o_runstop || o_clear || mode_chg) begin
                    checks++;
                    if (!prev_done) begin
                        errors++;
                        $display("FAIL cmd_latency: command with prior-cycle rx_done=%0d, expected 1", prev_done);
                    end
                end
                prev_mode = o_mode;
                prev_done = o_rx_done;
            end
        end
    end

    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (3 * BIT) @(posedge clk);

        // 'R'
        expect_byte(8'h52, EV_RUN, 1'b0);
        send_byte(8'h52, 1'b1);
        drain("R");
        chk("R_data", o_rx_data, 8'h52);
        chk("R_mode", {7'd0, o_mode}, 8'h00);

        // 'c' then 'x' back-to-back
        expect_byte(8'h63, EV_CLR, 1'b0);
        expect_byte(8'h78, EV_NONE, 1'b0);
        send_byte(8'h63, 1'b1);
        send_byte(8'h78, 1'b1);
        drain("cx");
        chk("cx_data", o_rx_data, 8'h78);

        // 'M', 'm', 'M'
        expect_byte(8'h4D, EV_MODE, 1'b1);
        expect_byte(8'h6D, EV_MODE, 1'b0);
        expect_byte(8'h4D, EV_MODE, 1'b1);
        send_byte(8'h4D, 1'b1);
        send_byte(8'h6D, 1'b1);
        send_byte(8'h4D, 1'b1);
        drain("MmM");
        chk("MmM_mode", {7'd0, o_mode}, 8'h01);

        // Short glitch (5 ticks) then 'C'
        rx = 1'b0;
        repeat (20) @(posedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        expect_byte(8'h43, EV_CLR, 1'b0);
        send_byte(8'h43, 1'b1);
        drain("glitchC");
        chk("glitchC_data", o_rx_data, 8'h43);

        // Bad stop bit, break for 3 bit times, then 'r'
        push(EV_FERR, 8'd0);
        send_byte(8'h52, 1'b0);
        repeat (3 * BIT) @(posedge clk);
        rx = 1'b1;
        repeat (BIT) @(posedge clk);
        drain("ferr");
        chk("ferr_data_held", o_rx_data, 8'h43);
        expect_byte(8'h72, EV_RUN, 1'b0);
        send_byte(8'h72, 1'b1);
        drain("r");
        chk("r_data", o_rx_data, 8'h72);

        // Reset during data bit 4 with mode set
        chk("pre_reset_mode", {7'd0, o_mode}, 8'h01);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1) ? 1'b1 : 1'b0;
            repeat (BIT) @(posedge clk);
        end
        rx = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk_all_zero("midreset");
        repeat (10) @(posedge clk);
        rst = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        expect_byte(8'h52, EV_RUN, 1'b0);
        send_byte(8'h52, 1'b1);
        drain("postreset_R");
        chk("postreset_data", o_rx_data, 8'h52);
        chk("postreset_mode", {7'd0, o_mode}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
